config_frame_writer: RTL
========================

Name: config_frame_writer

Overview:
- Loads fabric configuration frames into the per-tile configuration latches; it is the write side of the latch-based configuration storage.
- Accepts a 32-bit word stream (valid/ready) of header+data pairs. For each pair it drives FrameData and a one-hot RowSelect, then pulses exactly one FrameStrobe bit (latch enable) with setup and hold margins.
- Sits between the bitstream source (UART/SPI loader) and the fabric frame distribution wires.

Parameters:
- ROWS, 16, number of fabric rows; RowSelect width.
- MAX_FRAMES, 20, frames per tile column; FrameStrobe width.
- SYNC, 8'hFA, required value of header bits [31:24].

Ports:
- CLK  input  1  fabric configuration clock.
- RST  input  1  synchronous active-high reset.
- S_DATA  input  32  stream word (header or data).
- S_VALID  input  1  S_DATA valid.
- S_READY  output  1  word accepted when S_VALID&S_READY at rising CLK.
- FrameData  output  32  frame bit vector to latch D inputs.
- RowSelect  output  ROWS  one-hot row being written.
- FrameStrobe  output  MAX_FRAMES  one-hot latch-enable pulse.
- Busy  output  1  high in any state other than IDLE.
- Err  output  1  sticky error flag.
- FrameCount  output  16  number of frames strobed since reset, wraps at 16'hFFFF->0.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, S_READY=1, FrameData=0, RowSelect=0, FrameStrobe=0, Busy=0, Err=0, FrameCount=0. Asserting RST during SETUP/STROBE/HOLD forces all outputs to zero at that edge; no strobe is issued after it and no partial strobe is completed.
- Header format: [31:24] sync; [23:16] row index; [15:8] frame index; [7:1] reserved, ignored; [0] parity bit, used only with the optional feature.
- States: IDLE, WAIT_DATA, SETUP, STROBE, HOLD.
- IDLE: S_READY=1.
  - Accepted word with [31:24]==SYNC: latch row/frame/parity; go to WAIT_DATA.
  - Accepted word with [31:24]!=SYNC: set Err; word dropped; stay in IDLE.
- WAIT_DATA: S_READY=1.
  - Accepted word: register it to FrameData; go to SETUP.
  - If row>=ROWS or frame>=MAX_FRAMES: set Err, discard the data word, return to IDLE; FrameData/RowSelect are unchanged (remain 0).
- SETUP (1 cycle): S_READY=0. FrameData and RowSelect[row]=1 are driven; FrameStrobe=0.
- STROBE (1 cycle): S_READY=0. FrameStrobe[frame]=1, exactly one bit; FrameCount increments.
- HOLD (1 cycle): S_READY=0. FrameStrobe=0; FrameData and RowSelect held. Then go to IDLE.
- Outputs on return to IDLE: FrameData=0, RowSelect=0.
- FrameStrobe is registered and glitch-free. It is never high outside STROBE, and never high in two consecutive cycles.
- Latency: STROBE occurs 2 cycles after the data-word acceptance edge. Minimum 5 cycles per frame with S_VALID held high.
- No timeout in WAIT_DATA; the block waits indefinitely for the data word.
- Err clears only on RST.

Optional Feature:
- Macro: CFG_FRAME_PARITY_EN.
- Defined: in WAIT_DATA the data word is checked. If (^data) != header[0] (even parity over data, header[0] = XOR of data bits), Err is set, the frame is discarded, there is no strobe and no count, and the block returns to IDLE.
- Undefined: header[0] is ignored and no parity logic is generated.

Test Plan:
- Reset, then header 32'hFA03_0500 followed by data 32'hDEAD_BEEF with S_VALID held high -> SETUP shows FrameData=DEADBEEF, RowSelect=16'h0008. The next cycle shows FrameStrobe=20'h00020 for exactly 1 cycle. FrameCount=1. S_READY=0 for 3 cycles.
- Bad sync word 32'h1203_0500 in IDLE -> Err=1, no strobe, state stays IDLE; a following valid header/data pair still writes normally.
- Header with row 8'h10 (ROWS=16) or frame 8'd20, then any data word -> Err=1, no strobe, FrameCount unchanged, returns to IDLE.
- S_VALID deasserted for 7 cycles between header and data -> outputs stay 0 and S_READY=1 while waiting. Strobe fires 2 cycles after data acceptance.
- RST asserted during SETUP -> FrameStrobe never rises; all outputs are 0 the next cycle; FrameCount=0.
- CFG_FRAME_PARITY_EN defined:
  - Data 32'h0000_0001 with header[0]=1 -> strobe issued.
  - Same data with header[0]=0 -> Err=1 and no strobe.

Source files
------------

// File: rtl/config_frame_writer.sv
// Write side of the latch-based fabric configuration store: header+data word pairs become one-hot
// row/frame latch strobes with setup and hold cycles. Optional data parity check: `CFG_FRAME_PARITY_EN.
module config_frame_writer #(
  parameter int          ROWS       = 16,
  parameter int          MAX_FRAMES = 20,
  parameter logic [7:0]  SYNC       = 8'hFA
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           S_DATA,
  input  logic                  S_VALID,
  output logic                  S_READY,
  output logic [31:0]           FrameData,
  output logic [ROWS-1:0]       RowSelect,
  output logic [MAX_FRAMES-1:0] FrameStrobe,
  output logic                  Busy,
  output logic                  Err,
  output logic [15:0]           FrameCount,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    SETUP     = 3'd2,
    STROBE    = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] row_q, frame_q;
  logic       sync_ok, index_ok, parity_ok;
  logic       frame_go, sync_err, data_err;

  // Handshake: a word transfers on a rising CLK where S_VALID and S_READY are both high;
  // S_READY depends only on state, never on S_VALID.
  assign sync_ok  = (S_DATA[31:24] == SYNC);
  assign index_ok = ({24'd0, row_q} < 32'(ROWS)) && ({24'd0, frame_q} < 32'(MAX_FRAMES));

`ifdef CFG_FRAME_PARITY_EN
  logic par_q;
  assign parity_ok = ((^S_DATA) == par_q);
`else
  assign parity_ok = 1'b1;
`endif

  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    S_READY   = 1'b0;
    Busy      = 1'b1;
    frame_go  = 1'b0;
    sync_err  = 1'b0;
    data_err  = 1'b0;
    case (state)
      IDLE: begin
        S_READY = 1'b1;
        Busy    = 1'b0;
        if (S_VALID) begin
          if (sync_ok) state_nxt = WAIT_DATA;
          else         sync_err  = 1'b1;
        end
      end
      WAIT_DATA: begin
        S_READY = 1'b1;
        if (S_VALID) begin
          if (index_ok && parity_ok) begin
            frame_go  = 1'b1;
            state_nxt = SETUP;
          end else begin
            data_err  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      SETUP:   state_nxt = STROBE;
      STROBE:  state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_q       <= '0;
      frame_q     <= '0;
      FrameData   <= '0;
      RowSelect   <= '0;
      FrameStrobe <= '0;
      Err         <= 1'b0;
      FrameCount  <= '0;
`ifdef CFG_FRAME_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      if (state == IDLE && S_VALID && sync_ok) begin
        row_q   <= S_DATA[23:16];
        frame_q <= S_DATA[15:8];
`ifdef CFG_FRAME_PARITY_EN
        par_q   <= S_DATA[0];
`endif
      end
      if (sync_err || data_err) Err <= 1'b1;
      if (frame_go) begin
        FrameData <= S_DATA;
        RowSelect <= {{(ROWS-1){1'b0}}, 1'b1} << row_q;
      end else if (state == HOLD) begin
        FrameData <= '0;
        RowSelect <= '0;
      end
      // Strobe is a registered single-cycle pulse covering exactly the STROBE state.
      if (state == SETUP) begin
        FrameStrobe <= {{(MAX_FRAMES-1){1'b0}}, 1'b1} << frame_q;
        FrameCount  <= FrameCount + 16'd1;
      end else begin
        FrameStrobe <= '0;
      end
    end
  end

endmodule
